// File: rtl/simt_exec_ctrl_if.sv
// rtl/simt_exec_ctrl_if.sv - instruction fetch and register file port bundle for simt_exec_ctrl
interface simt_exec_ctrl_if #(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) ();
    logic [PC_W-1:0]    imem_addr;
    logic [DATA_W-1:0]  imem_data;
    logic [RADDR_W-1:0] rna;
    logic [RADDR_W-1:0] rnb;
    logic [RADDR_W-1:0] rnc;
    logic [DATA_W-1:0]  qa;
    logic [DATA_W-1:0]  qb;
    logic [DATA_W-1:0]  qc;
    logic [DATA_W-1:0]  d;
    logic [RADDR_W-1:0] wn;
    logic               we;

    modport master (
        output imem_addr, rna, rnb, rnc, d, wn, we,
        input  imem_data, qa, qb, qc
    );

    modport slave (
        input  imem_addr, rna, rnb, rnc, d, wn, we,
        output imem_data, qa, qb, qc
    );
endinterface

// File: rtl/simt_exec_ctrl.sv
// rtl/simt_exec_ctrl.sv - four-cycle instruction sequencer and ALU in front of the register file
module simt_exec_ctrl #(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    simt_exec_ctrl_if.master bus,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_tgt;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   res;
    logic [RADDR_W-1:0]  wn_q;
    logic                we_q;

    logic [3:0]          op;
    logic [DATA_W-1:0]   alu_res;
    logic                wr_op;
    logic [PC_W-1:0]     pc_next;
    logic [PC_W-1:0]     pc_inc;

    assign op     = ir[15:12];
    assign pc_inc = pc + PC_W'(1);

    assign bus.imem_addr = pc;
    assign bus.rna       = ir[7:4];
    assign bus.rnb       = ir[3:0];
    assign bus.rnc       = ir[11:8];
    assign bus.d         = res;
    assign bus.wn        = wn_q;
    assign bus.we        = we_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // start is only honoured from IDLE or HALTED; every other state advances unconditionally
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                busy    = 1'b1;
                state_n = S_EXECUTE;
            end
            S_EXECUTE: begin
                busy    = 1'b1;
                state_n = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                busy    = 1'b1;
                state_n = (op == OP_HALT) ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (start) state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        wr_op   = 1'b0;
        case (op)
            OP_ADD: begin alu_res = bus.qa + bus.qb;             wr_op = 1'b1; end
            OP_SUB: begin alu_res = bus.qa - bus.qb;             wr_op = 1'b1; end
            OP_AND: begin alu_res = bus.qa & bus.qb;             wr_op = 1'b1; end
            OP_OR:  begin alu_res = bus.qa | bus.qb;             wr_op = 1'b1; end
            OP_XOR: begin alu_res = bus.qa ^ bus.qb;             wr_op = 1'b1; end
            OP_SHL: begin alu_res = bus.qa << bus.qb[3:0];       wr_op = 1'b1; end
            OP_SHR: begin alu_res = bus.qa >> bus.qb[3:0];       wr_op = 1'b1; end
            OP_LDI: begin alu_res = {{(DATA_W-8){1'b0}}, ir[7:0]}; wr_op = 1'b1; end
            OP_MOV: begin alu_res = bus.qa;                      wr_op = 1'b1; end
            OP_INC: begin alu_res = bus.qa + DATA_W'(1);         wr_op = 1'b1; end
            default: begin alu_res = '0;                         wr_op = 1'b0; end
        endcase
    end

    // HALT keeps pc so the halted pc points at the HALT instruction itself
    always_comb begin
        pc_next = pc_inc;
        case (op)
            OP_BNZ:  pc_next = (bus.qc != '0) ? PC_W'(ir[7:0]) : pc_inc;
            OP_JMP:  pc_next = PC_W'(ir[7:0]);
            OP_HALT: pc_next = pc;
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc     <= '0;
            pc_tgt <= '0;
            ir     <= '0;
            res    <= '0;
            wn_q   <= '0;
            we_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) pc <= '0;
                end
                S_DECODE: begin
                    ir <= bus.imem_data;
                end
                S_EXECUTE: begin
                    res    <= alu_res;
                    wn_q   <= ir[11:8];
                    we_q   <= wr_op;
                    pc_tgt <= pc_next;
                end
                S_WRITEBACK: begin
                    pc <= pc_tgt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simt_exec_ctrl.sv
// tb/tb_simt_exec_ctrl.sv - scoreboard bench for simt_exec_ctrl against an instruction-level model
module tb_simt_exec_ctrl;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic start  = 1'b0;
    logic busy;
    logic halted;

    simt_exec_ctrl_if bus ();

    simt_exec_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .bus    (bus.master),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clock = ~clock;

    logic [15:0] rom [256];
    logic [15:0] rf  [16];
    logic        rf_clr = 1'b1;

    always @(posedge clock) bus.imem_data <= rom[bus.imem_addr];

    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (bus.we) begin
            rf[bus.wn] <= bus.d;
        end
    end

    assign bus.qa = rf[bus.rna];
    assign bus.qb = rf[bus.rnb];
    assign bus.qc = rf[bus.rnc];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [3:0]  wn;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          exp_pc[$];
    logic [15:0] mrf [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          s_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic load(input logic [15:0] p[8]);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rom[i] = p[i];
    endtask

    // Instruction-level interpreter; reset after cycle c_r keeps only write-backs at cycle <= c_r
    task automatic model(input int c_r, output bit did_halt, output int hk, output int hpc);
        int          pc;
        int          nxt;
        bit          wr;
        logic [15:0] w, a, b, cc, val;
        logic [3:0]  op, rd;
        pc = 0; did_halt = 1'b0; hk = -1; hpc = 0;
        exp_pc.delete();
        for (int k = 0; 4 * k + 1 <= c_r; k++) begin
            w  = rom[pc];
            op = w[15:12];
            rd = w[11:8];
            a  = mrf[w[7:4]];
            b  = mrf[w[3:0]];
            cc = mrf[rd];
            exp_pc.push_back(pc);
            nxt = (pc + 1) % 256;
            wr  = 1'b1;
            val = 16'h0000;
            case (op)
                4'h1: val = a + b;
                4'h2: val = a - b;
                4'h3: val = a & b;
                4'h4: val = a | b;
                4'h5: val = a ^ b;
                4'h6: val = a << b[3:0];
                4'h7: val = a >> b[3:0];
                4'h8: val = {8'h00, w[7:0]};
                4'h9: val = a;
                4'hA: val = a + 16'd1;
                4'hB: begin wr = 1'b0; if (cc != 16'h0000) nxt = int'(w[7:0]); end
                4'hC: begin wr = 1'b0; nxt = int'(w[7:0]); end
                4'hF: begin wr = 1'b0; did_halt = (4 * k + 4 < c_r); hk = k; hpc = pc; end
                default: wr = 1'b0;
            endcase
            if (op == 4'hF) break;
            if (4 * k + 4 > c_r) break;
            if (wr) begin
                mrf[rd] = val;
                exp_q.push_back('{c: 4 * k + 4, wn: rd, d: val});
            end
            pc = nxt;
        end
    endtask

    // c_r: cycle at whose end reset is sampled (ignored if HALT comes first); c_s: cycle to pulse start
    task automatic run(input int c_r, input int c_s);
        bit did_halt;
        int hk, hpc, end_c, c;
        model(c_r, did_halt, hk, hpc);
        end_c = did_halt ? 4 * hk + 5 : c_r + 1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        s_cyc = cyc;
        c = 1;
        forever begin
            if (c % 4 == 1 && c / 4 < exp_pc.size())
                check("fetch_addr", 32'(bus.imem_addr), exp_pc[c / 4]);
            if (c < end_c) check("busy_run", 32'(busy), 1);
            if (c == end_c) begin
                if (did_halt) begin
                    check("halted_end", 32'(halted), 1);
                    check("busy_end", 32'(busy), 0);
                    check("halt_pc", 32'(bus.imem_addr), hpc);
                end else begin
                    check("rst_we", 32'(bus.we), 0);
                    check("rst_busy", 32'(busy), 0);
                    check("rst_halted", 32'(halted), 0);
                    check("rst_pc", 32'(bus.imem_addr), 0);
                    resetn = 1'b1;
                end
                break;
            end
            if (!did_halt && c == c_r) resetn = 1'b0;
            start = (c == c_s);
            @(negedge clock);
            c++;
        end
        start = 1'b0;
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) check($sformatf("rf_r%0d", i), 32'(rf[i]), 32'(mrf[i]));
    endtask

    initial begin
        fork
            begin : monitor
                wr_t e;
                forever begin
                    @(negedge clock);
                    if (bus.we === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_write: got we=1 wn=%h d=%h want no write (cycle %0d)",
                                     bus.wn, bus.d, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("wb_cycle", cyc - s_cyc + 1, e.c);
                            check("wb_reg", 32'(bus.wn), 32'(e.wn));
                            check("wb_data", 32'(bus.d), 32'(e.d));
                        end
                    end
                end
            end
            begin : stimulus
                logic [15:0] w;
                int          c_r;
                for (int i = 0; i < 16; i++) mrf[i] = 16'h0000;
                for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
                resetn = 1'b0;
                repeat (3) @(negedge clock);
                rf_clr = 1'b0;
                check("init_we", 32'(bus.we), 0);
                check("init_busy", 32'(busy), 0);
                check("init_halted", 32'(halted), 0);
                check("init_pc", 32'(bus.imem_addr), 0);
                check("init_d", 32'(bus.d), 0);
                check("init_wn", 32'(bus.wn), 0);
                check("init_rn", 32'({bus.rna, bus.rnb, bus.rnc}), 0);
                resetn = 1'b1;

                load('{16'h8105, 16'h8207, 16'h1312, 16'hF000, 0, 0, 0, 0});
                run(1000, 0);
                run(1000, 6);
                run(1000, 16);
                load('{16'h8400, 16'hA440, 16'h2540, 16'hF000, 0, 0, 0, 0});
                run(1000, 3);
                load('{16'h8400, 16'h8101, 16'h2641, 16'hF000, 0, 0, 0, 0});
                run(1000, 0);
                load('{16'h8603, 16'h2661, 16'hB601, 16'hF000, 0, 0, 0, 0});
                run(1000, 9);
                load('{16'h8101, 16'hA110, 16'hC0FF, 0, 0, 0, 0, 0});
                run(34, 0);
                load('{16'h8103, 16'h8205, 16'h1312, 16'h1312, 16'hC000, 0, 0, 0});
                run(11, 0);

                for (int t = 0; t < 14; t++) begin
                    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
                    for (int i = 0; i < 16; i++) begin
                        w = 16'($urandom);
                        if (w[15:12] == 4'hB || w[15:12] == 4'hC) w[7:0] = 8'($urandom_range(0, 15));
                        rom[i] = w;
                    end
                    c_r = $urandom_range(6, 160);
                    run(c_r, $urandom_range(1, c_r));
                end
                repeat (2) @(negedge clock);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
